// File: rtl/channel_err_inj_if.sv
// Symbol stream and status bundle for the channel error injector.
// master drives symbols and mode; slave is the injector.
interface channel_err_inj_if;
    logic        enable_i;
    logic [1:0]  d_in;
    logic [1:0]  mode_i;
    logic        valid_o;
    logic [1:0]  d_out;
    logic [1:0]  err_o;
    logic [15:0] word_ct_o;
    logic [15:0] bad_bit_ct_o;

    modport master (
        output enable_i, d_in, mode_i,
        input  valid_o, d_out, err_o, word_ct_o, bad_bit_ct_o
    );

    modport slave (
        input  enable_i, d_in, mode_i,
        output valid_o, d_out, err_o, word_ct_o, bad_bit_ct_o
    );
endinterface

// File: rtl/channel_err_inj.sv
// Channel error injector: one-cycle symbol pipe that flips bits in periodic
// bursts or by LFSR-driven random draws, with saturating symbol/bit counters.
module channel_err_inj #(
    parameter int          N         = 5,
    parameter int          BURST_LEN = 8,
    parameter logic [1:0]  ERR_MASK  = 2'b01,
    parameter int          WINDOW    = 256,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter logic [7:0]  THRESH    = 8'd16
) (
    input logic               clk,
    input logic               rst,
    channel_err_inj_if.slave  bus
);

    localparam int BURST_START = (1 << N) - BURST_LEN;

    logic [15:0] lfsr;
    logic [15:0] word_ct;
    logic [15:0] bad_ct;
    logic        valid_q;
    logic [1:0]  dout_q;
    logic [1:0]  err_q;

    logic [31:0] phase;
    logic        win_ok;
    logic        burst_hit;
    logic        lo_hit;
    logic        hi_hit;
    logic [1:0]  e;
    logic [1:0]  e_cnt;
    logic [16:0] bad_sum;
    logic        lfsr_fb;

    // Saturated word_ct stays at 16'hFFFF, which always falls outside WINDOW.
    assign phase     = 32'(word_ct[N-1:0]);
    assign win_ok    = 32'(word_ct) < 32'(WINDOW);
    assign burst_hit = phase >= 32'(BURST_START);
    assign lo_hit    = lfsr[7:0]  < THRESH;
    assign hi_hit    = lfsr[15:8] < THRESH;

    always_comb begin
        e = 2'b00;
        if (win_ok) begin
            case (bus.mode_i)
                2'b01:   e = burst_hit ? ERR_MASK : 2'b00;
                2'b10:   e = lo_hit ? ERR_MASK : 2'b00;
                2'b11:   e = {hi_hit, lo_hit};
                default: e = 2'b00;
            endcase
        end
    end

    assign e_cnt   = {1'b0, e[1]} + {1'b0, e[0]};
    assign bad_sum = {1'b0, bad_ct} + 17'(e_cnt);
    assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr    <= LFSR_SEED;
            word_ct <= '0;
            bad_ct  <= '0;
            valid_q <= 1'b0;
            dout_q  <= '0;
            err_q   <= '0;
        end else begin
            valid_q <= bus.enable_i;
            if (bus.enable_i) begin
                dout_q  <= bus.d_in ^ e;
                err_q   <= e;
                lfsr    <= {lfsr[14:0], lfsr_fb};
                bad_ct  <= bad_sum[16] ? 16'hFFFF : bad_sum[15:0];
                if (word_ct != 16'hFFFF)
                    word_ct <= word_ct + 16'd1;
            end
        end
    end

    assign bus.valid_o      = valid_q;
    assign bus.d_out        = dout_q;
    assign bus.err_o        = err_q;
    assign bus.word_ct_o    = word_ct;
    assign bus.bad_bit_ct_o = bad_ct;

endmodule

// File: doc/channel_err_inj.md
CHANNEL_ERR_INJ -- requirements
Module: channel_err_inj

Interface
REQ-001 The block SHALL have these parameters:
- N, 5: burst period is 2**N symbols; legal range 3..15.
- BURST_LEN, 8: corrupted symbols per period; legal range 1..2**N.
- ERR_MASK, 2'b01: bits inverted on a corrupted symbol in modes 01 and 10.
- WINDOW, 256: injection allowed only while the symbol index is below WINDOW.
- LFSR_SEED, 16'hACE1: LFSR reset value; must be nonzero.
- THRESH, 8'd16: random error when the selected LFSR byte is below THRESH.
REQ-002 The block SHALL have these ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: asynchronous, active-low reset.
- enable_i, input, 1: d_in valid this cycle; symbol accepted.
- d_in, input, 2: encoder symbol.
- mode_i, input, 2: 00 pass, 01 periodic burst, 10 random per-symbol, 11 random per-bit.
- valid_o, output, 1: d_out valid.
- d_out, output, 2: possibly corrupted symbol.
- err_o, output, 2: bits inverted in the current d_out.
- word_ct_o, output, 16: accepted-symbol count.
- bad_bit_ct_o, output, 16: total inverted bits.

Function
REQ-003 A symbol SHALL be accepted on every rising clk edge where enable_i=1; there is no backpressure.
REQ-004 Latency SHALL be exactly 1 cycle: for a symbol accepted at edge k, valid_o=1, d_out=d_in^e and err_o=e after edge k, where e is the error vector for that symbol.
REQ-005 On edges with enable_i=0, valid_o SHALL go to 0; d_out, err_o and both counters SHALL hold.
REQ-006 Index w SHALL be the value of word_ct_o before increment; word_ct_o SHALL increment per accepted symbol and saturate at 16'hFFFF.
REQ-007 If w >= WINDOW, e SHALL be 2'b00 regardless of mode.
REQ-008 Mode 00 SHALL give e=2'b00.
REQ-009 Mode 01 SHALL give e=ERR_MASK when w[N-1:0] >= 2**N-BURST_LEN, else 2'b00.
REQ-010 Mode 10 SHALL give e=ERR_MASK when lfsr[7:0] < THRESH, else 2'b00.
REQ-011 Mode 11 SHALL give e[0]=(lfsr[7:0] < THRESH) and e[1]=(lfsr[15:8] < THRESH), independent of ERR_MASK.
REQ-012 The LFSR SHALL be 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1, shifting left with feedback = lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10] into bit 0.
REQ-013 The LFSR SHALL advance once per accepted symbol in every mode, and e SHALL use the pre-advance value.
REQ-014 mode_i SHALL be sampled per accepted symbol; a mode change takes effect on the next accepted symbol with no flush.
REQ-015 bad_bit_ct_o SHALL add popcount(e) (0..2) per accepted symbol and saturate at 16'hFFFF, never wrapping.
REQ-016 On the saturation boundary, bad_bit_ct_o = 16'hFFFE plus 2 SHALL give 16'hFFFF.
REQ-017 Once word_ct_o saturates, w stays 16'hFFFF, which is >= WINDOW for every legal WINDOW, so no injection occurs.

Reset
REQ-018 While rst=0, the block SHALL immediately and asynchronously force valid_o=0, d_out=0, err_o=0, word_ct_o=0, bad_bit_ct_o=0 and lfsr=LFSR_SEED.
REQ-019 Reset asserted mid-stream SHALL discard the in-flight symbol.
REQ-020 After reset release, the first accepted symbol SHALL have w=0 and use lfsr=LFSR_SEED.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Mode 00, 300 symbols d_in=2'b10 -> d_out=2'b10 one cycle after each enable_i; err_o=0; bad_bit_ct_o=0; word_ct_o=300.
- Mode 01, defaults, 300 symbols -> err_o=2'b01 exactly for w mod 32 in 24..31 and w<256; bad_bit_ct_o=64 at end; no errors for w>=256.
- Mode 10, THRESH=226 -> first symbol after reset corrupted (seed byte 8'hE1=225 < 226); THRESH=225 -> first symbol clean; full 256-symbol run matches bit-accurate LFSR model.
- Mode 11, THRESH=8'hFF -> each bit flipped unless its LFSR byte is 8'hFF; bad_bit_ct_o equals model popcount sum.
- enable_i toggling 1/0 every cycle, mode 01 -> identical d_out/err_o sequence to continuous run; valid_o low on idle cycles; word_ct_o counts accepted symbols only.
- rst pulsed low at symbol 100 mid-cycle -> all outputs 0 before the next edge; after release, the output sequence repeats identically from w=0.
